// File: rtl/moving_avg_8.sv
// rtl/moving_avg_8.sv - 8-sample moving average with hysteresis threshold flag
module moving_avg_8 #(
  parameter int HYST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  din,
  input  logic [7:0]  din_dly,
  input  logic [7:0]  thr,
  output logic [10:0] sum,
  output logic [7:0]  avg,
  output logic        avg_valid,
  output logic        above
);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A hysteresis of 256 or more can never be met by an 8-bit avg, so clearing is disabled.
  localparam bit          CLEAR_EN = (HYST < 256);
  localparam logic [8:0]  HYST_W   = CLEAR_EN ? 9'(HYST) : 9'd0;

  state_t      state;
  state_t      state_next;
  logic [2:0]  cnt;
  logic [2:0]  cnt_next;
  logic [10:0] sum_next;
  logic        above_next;
  logic [8:0]  thr_low;

  // The window is complete exactly while the FSM is in RUN.
  assign avg_valid = (state == RUN);

  // State register plus registered datapath; rst and clr both restart the window.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= FILL;
      cnt   <= 3'd0;
      sum   <= 11'd0;
      avg   <= 8'd0;
      above <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sum   <= sum_next;
      avg   <= sum_next[10:3];
      above <= above_next;
    end
  end

  // Next-state logic: leave FILL on the edge that accepts the 8th sample.
  always_comb begin
    state_next = state;
    if (state == FILL && cnt == 3'd7) begin
      state_next = RUN;
    end
  end

  // Datapath: FILL only accumulates, RUN adds the new sample and drops the oldest.
  always_comb begin
    sum_next = sum;
    cnt_next = cnt;
    case (state)
      FILL: begin
        sum_next = sum + {3'b000, din};
        cnt_next = cnt + 3'd1;
      end
      RUN: begin
        sum_next = sum + {3'b000, din} - {3'b000, din_dly};
      end
      default: begin
        sum_next = sum;
        cnt_next = cnt;
      end
    endcase
  end

  // Threshold flag from the registered avg; the clear level saturates at zero.
  always_comb begin
    thr_low    = ({1'b0, thr} > HYST_W) ? ({1'b0, thr} - HYST_W) : 9'd0;
    above_next = above;
    if (!avg_valid) begin
      above_next = 1'b0;
    end else if (avg >= thr) begin
      above_next = 1'b1;
    end else if (CLEAR_EN && ({1'b0, avg} < thr_low)) begin
      above_next = 1'b0;
    end
  end

endmodule
